slave_in_port: RTL

//  Slave-side receive port for the serial system bus: the downstream consumer of a master's output port.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bit_deserializer.sv | 36 +++
 rtl/slave_in_port.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus ports.
// State encodings, op codes and default field widths.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RECEIVE      = 3'd1,
    ST_MEM_WRITE    = 3'd2,
    ST_MEM_READ     = 3'd3,
    ST_WAIT_READ_TX = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_INACTIVE = 2'b00,
    OP_WRITE    = 2'b10,
    OP_READ     = 2'b11
  } op_e;

  localparam int ADDR_LEN_DEF = 12;
  localparam int DATA_LEN_DEF = 8;

  function automatic int max_len(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_deserializer.sv
// Bit-indexed shift-free deserialiser: writes one bit at a given index.
// Exposes the next-state word so the caller can latch the final bit same edge.
module bit_deserializer #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [IDXW-1:0]  idx_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] nxt_o
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;

  // Indices at or beyond WIDTH match no bit and are dropped.
  always_comb begin
    shadow_d = clr_i ? '0 : shadow_q;
    if (en_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (idx_i == IDXW'(i)) shadow_d[i] = bit_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end

  assign nxt_o = shadow_d;

endmodule

// File: rtl/slave_in_port.sv
// Slave-side receive port: deserialises address/data from the master,
// issues one memory request and holds the bus for reads until data returns.
module slave_in_port
  import bus_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                master_valid,
  input  logic                write_en,
  input  logic                read_en,
  input  logic                rx_address,
  input  logic                rx_data,
  output logic                slave_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_write,
  output logic                mem_read,
  input  logic                mem_ack,
  input  logic                read_done,
  output logic                rx_done
);

  localparam int MAXLEN = max_len(ADDR_LEN, DATA_LEN);
  localparam int CW     = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(MAXLEN - 1);

  state_e              state_q;
  op_e                 op_q;
  logic [CW-1:0]       cnt_q;
  logic                ready_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic                mem_write_q;
  logic                mem_read_q;
  logic                rx_done_q;

  logic                hs;
  logic                rx_bit;
  logic [CW-1:0]       idx;
  logic                addr_en;
  logic                data_en;
  logic [ADDR_LEN-1:0] addr_nxt;
  logic [DATA_LEN-1:0] data_nxt;

  assign hs = (state_q == ST_IDLE) & master_valid & ready_q
            & (write_en ^ read_en);
  assign rx_bit = (state_q == ST_RECEIVE) & master_valid;
  assign idx = hs ? '0 : cnt_q;
  assign addr_en = hs | rx_bit;
  assign data_en = hs ? write_en : (rx_bit & (op_q == OP_WRITE));

  bit_deserializer #(.WIDTH(ADDR_LEN), .IDXW(CW)) u_addr_des (
    .clk   (clk),
    .reset (reset),
    .clr_i (hs),
    .en_i  (addr_en),
    .idx_i (idx),
    .bit_i (rx_address),
    .nxt_o (addr_nxt)
  );

  bit_deserializer #(.WIDTH(DATA_LEN), .IDXW(CW)) u_data_des (
    .clk   (clk),
    .reset (reset),
    .clr_i (hs),
    .en_i  (data_en),
    .idx_i (idx),
    .bit_i (rx_data),
    .nxt_o (data_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_INACTIVE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      rx_done_q   <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            op_q    <= write_en ? OP_WRITE : OP_READ;
            cnt_q   <= CW'(1);
            ready_q <= 1'b0;
            state_q <= ST_RECEIVE;
          end
        end
        ST_RECEIVE: begin
          if (!master_valid) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else if (cnt_q == LAST) begin
            addr_q <= addr_nxt;
            if (op_q == OP_WRITE) begin
              wdata_q     <= data_nxt;
              mem_write_q <= 1'b1;
              state_q     <= ST_MEM_WRITE;
            end else begin
              mem_read_q <= 1'b1;
              state_q    <= ST_MEM_READ;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_MEM_WRITE: begin
          if (mem_ack) begin
            mem_write_q <= 1'b0;
            rx_done_q   <= 1'b1;
            ready_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        ST_MEM_READ: begin
          if (mem_ack) begin
            mem_read_q <= 1'b0;
            rx_done_q  <= 1'b1;
            state_q    <= ST_WAIT_READ_TX;
          end
        end
        ST_WAIT_READ_TX: begin
          if (read_done) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          op_q        <= OP_INACTIVE;
          cnt_q       <= '0;
          ready_q     <= 1'b1;
          addr_q      <= '0;
          wdata_q     <= '0;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          rx_done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign slave_ready = ready_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign rx_done     = rx_done_q;

endmodule
